alu_rr_sequencer: RTL and testbench

//   Shares one combinational ALU between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_rr_sequencer_if.sv | 49 ++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/alu_rr_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_rr_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcodes, sequencer states and
// response flag payload.
package alu_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OPW   = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_RSH = 3'b001,
    OP_LSH = 3'b010,
    OP_XOR = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic zero;
    logic sign;
    logic err;
  } rsp_flags_t;

  // Opcodes above OP_XOR are reserved and never reach the ALU result path.
  function automatic logic is_legal_op(input int unsigned op);
    return op <= 32'(OP_XOR);
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Request, ALU and response signals of the shared-ALU sequencer.
// The master modport is the sequencer side, slave is its environment.
interface alu_rr_sequencer_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned OPW     = alu_pkg::OPW,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*OPW-1:0]   req_op;

  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [OPW-1:0]           alu_op;
  logic [WIDTH-1:0]         alu_out;
  logic                     alu_zero;
  logic                     alu_sign;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_zero;
  logic                     rsp_sign;
  logic                     rsp_err;

  modport master (
    input  req_valid, req_a, req_b, req_op,
    output req_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_zero, alu_sign,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_a, req_b, req_op,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_zero, alu_sign,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  always_comb begin
    logic        found;
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[IDW'(j)]) begin
        found            = 1'b1;
        grant[IDW'(j)]   = 1'b1;
        grant_idx        = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one external combinational ALU between NUM_REQ requesters using a
// round-robin pick, returning tagged results on a single response port.
module alu_rr_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned OPW     = alu_pkg::OPW,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                clk,
  input logic                reset,
  alu_rr_sequencer_if.master bus
);

  seq_state_e         state_q;
  seq_state_e         state_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_req;

  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [OPW-1:0]     op_q;
  logic [WIDTH-1:0]   result_q;
  rsp_flags_t         flags_q;

  logic [WIDTH-1:0]   a_arr  [NUM_REQ];
  logic [WIDTH-1:0]   b_arr  [NUM_REQ];
  logic [OPW-1:0]     op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = bus.req_a[g*WIDTH +: WIDTH];
    assign b_arr[g]  = bus.req_b[g*WIDTH +: WIDTH];
    assign op_arr[g] = bus.req_op[g*OPW +: OPW];
  end

  assign any_req = |bus.req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is only offered while idle; everything else comes from registers.
  always_comb begin
    bus.req_ready  = '0;
    bus.rsp_valid  = 1'b0;
    bus.alu_a      = a_q;
    bus.alu_b      = b_q;
    bus.alu_op     = op_q;
    bus.rsp_id     = id_q;
    bus.rsp_result = result_q;
    bus.rsp_zero   = flags_q.zero;
    bus.rsp_sign   = flags_q.sign;
    bus.rsp_err    = flags_q.err;
    case (state_q)
      IDLE:    bus.req_ready = grant;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, result capture and pointer rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            a_q  <= a_arr[grant_idx];
            b_q  <= b_arr[grant_idx];
            op_q <= op_arr[grant_idx];
            id_q <= grant_idx;
          end
        end
        EXEC: begin
          if (is_legal_op(32'(op_q))) begin
            result_q <= bus.alu_out;
            flags_q  <= '{zero: bus.alu_zero, sign: bus.alu_sign, err: 1'b0};
          end else begin
            result_q <= '0;
            flags_q  <= '{zero: 1'b1, sign: 1'b0, err: 1'b1};
          end
        end
        RESP: begin
          if (bus.rsp_ready) ptr_q <= IDW'((32'(id_q) + 32'd1) % NUM_REQ);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench for alu_rr_sequencer with two requesters and a reference
// ALU attached to the ALU port.
module tb_alu_rr_sequencer;

  logic clk;
  logic reset;

  alu_rr_sequencer_if #(.NUM_REQ(2), .WIDTH(8), .OPW(3), .IDW(1)) bus ();

  alu_rr_sequencer #(.NUM_REQ(2), .WIDTH(8), .OPW(3), .IDW(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0] sa  [2][32];
  logic [7:0] sb_ [2][32];
  logic [2:0] sop [2][32];
  int         cnt     [2];
  int         acc_cnt [2];

  logic [31:0] sb [$];
  logic        busy;
  logic        tb_ptr;
  int          acc_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a >> 1;
      3'b010:  return a << 1;
      3'b011:  return a ^ b;
      default: return 8'hA5;
    endcase
  endfunction

  // Reference ALU; reserved opcodes give a recognisable nonzero pattern.
  always_comb begin
    logic [7:0] r;
    r            = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    bus.alu_out  = r;
    bus.alu_zero = (r == 8'h00);
    bus.alu_sign = r[7];
  end

  // Packed as {id, err, zero, sign, result}.
  function automatic logic [31:0] exp_rsp(input logic id, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] op);
    logic [7:0] r;
    if (op[2]) return {20'd0, id, 1'b1, 1'b1, 1'b0, 8'h00};
    r = alu_fn(a, b, op);
    return {20'd0, id, 1'b0, (r == 8'h00), r[7], r};
  endfunction

  function automatic int first_valid(input logic ptr, input logic [1:0] v);
    for (int k = 0; k < 2; k++) begin
      int j;
      j = (int'(ptr) + k) % 2;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  task automatic push_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    sa[i][cnt[i]]  = a;
    sb_[i][cnt[i]] = b;
    sop[i][cnt[i]] = op;
    cnt[i]         = cnt[i] + 1;
  endtask

  // Requester driver: hold the current op until accepted, then advance.
  initial forever begin
    for (int i = 0; i < 2; i++) begin
      if (acc_cnt[i] < cnt[i]) begin
        bus.req_valid[i]      = 1'b1;
        bus.req_a[i*8 +: 8]   = sa[i][acc_cnt[i]];
        bus.req_b[i*8 +: 8]   = sb_[i][acc_cnt[i]];
        bus.req_op[i*3 +: 3]  = sop[i][acc_cnt[i]];
      end else begin
        bus.req_valid[i]      = 1'b0;
        bus.req_a[i*8 +: 8]   = 8'h00;
        bus.req_b[i*8 +: 8]   = 8'h00;
        bus.req_op[i*3 +: 3]  = 3'b000;
      end
    end
    @(posedge clk);
    #1;
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    logic [31:0] cur;
    logic [31:0] held_val;
    logic [31:0] e;
    logic        held;
    logic        exp_rv;
    int          g;
    busy = 1'b0;
    tb_ptr = 1'b0;
    held = 1'b0;
    held_val = '0;
    acc_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        busy   = 1'b0;
        tb_ptr = 1'b0;
        held   = 1'b0;
      end else begin
        if (busy) begin
          check("ready_busy", 32'(bus.req_ready), 32'd0);
        end else if (bus.req_valid != 2'b00) begin
          g = first_valid(tb_ptr, bus.req_valid);
          check("grant", 32'(bus.req_ready), 32'(2'b01 << g));
          sb.push_back(exp_rsp(g[0], sa[g][acc_cnt[g]], sb_[g][acc_cnt[g]], sop[g][acc_cnt[g]]));
          busy    = 1'b1;
          acc_cyc = cyc;
        end else begin
          check("ready_idle", 32'(bus.req_ready), 32'd0);
        end
        for (int i = 0; i < 2; i++)
          if (bus.req_ready[i] && bus.req_valid[i]) acc_cnt[i] = acc_cnt[i] + 1;

        exp_rv = busy && ((cyc - acc_cyc) >= 2);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (bus.rsp_valid) begin
          cur = {20'd0, bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_sign, bus.rsp_result};
          if (held) check("rsp_hold", cur, held_val);
          if (bus.rsp_ready) begin
            if (sb.size() == 0) begin
              check("sb_empty", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check("rsp", cur, e);
              tb_ptr = ~e[11];
            end
            busy = 1'b0;
            held = 1'b0;
          end else begin
            held     = 1'b1;
            held_val = cur;
          end
        end
      end
    end
  end

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge clk);
      if (acc_cnt[0] == cnt[0] && acc_cnt[1] == cnt[1] && !busy && sb.size() == 0)
        done = 1'b1;
    end
    check("timeout", 32'(done), 32'd1);
    #1;
  endtask

  initial begin
    bit seen;
    reset         = 1'b1;
    bus.rsp_ready = 1'b1;
    cnt[0] = 0; cnt[1] = 0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_alu", {13'd0, bus.alu_a, bus.alu_b, bus.alu_op}, 32'd0);
    check("rst_rsp", {20'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_zero,
                      bus.rsp_sign, bus.rsp_result[6:0]}, 32'd0);
    check("rst_rdy", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // basic add with latency checked by the monitor
    push_op(0, 8'h01, 8'h01, 3'b000);
    wait_done();

    // two requesters held valid alternate
    push_op(0, 8'h05, 8'h05, 3'b011);
    push_op(0, 8'h05, 8'h05, 3'b011);
    push_op(1, 8'h81, 8'h00, 3'b010);
    push_op(1, 8'h81, 8'h00, 3'b010);
    wait_done();

    // consumer stalls four cycles in RESP
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    push_op(0, 8'h10, 8'h20, 3'b000);
    push_op(1, 8'h0F, 8'hF0, 3'b011);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("stall_seen", 32'(seen), 32'd1);
    repeat (4) @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_done();

    // reserved opcode
    push_op(1, 8'hFF, 8'hFF, 3'b101);
    wait_done();

    // flag boundaries
    push_op(0, 8'h7F, 8'h01, 3'b000);
    push_op(0, 8'h04, 8'h00, 3'b001);
    push_op(0, 8'hFF, 8'h01, 3'b000);
    push_op(0, 8'h80, 8'h00, 3'b010);
    wait_done();

    // reset while executing discards the op and clears the pointer
    push_op(0, 8'h11, 8'h22, 3'b000);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk);
      if (acc_cnt[0] == cnt[0]) seen = 1'b1;
    end
    check("rst_accept", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_rv", 32'(bus.rsp_valid), 32'd0);
    push_op(0, 8'h33, 8'h44, 3'b011);
    push_op(1, 8'h12, 8'h34, 3'b000);
    wait_done();
    push_op(1, 8'h01, 8'h02, 3'b000);
    wait_done();

    // random mix including reserved opcodes
    for (int n = 0; n < 8; n++)
      push_op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    wait_done();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule
